// File: rtl/ariane_pkg.sv
// Minimal slice of the core package: only the exception record that the CFI
// handler exchanges with the checkers and the commit/CSR path.
package ariane_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

endpackage

// File: rtl/cfi_pkg.sv
// Shared types for the CFI violation handler: FSM states, log entry layout
// and the source encoding stored with each logged violation.
package cfi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPORT = 2'd1,
    HOLD   = 2'd2
  } cfi_state_e;

  localparam logic CFI_SRC_CALL = 1'b0;
  localparam logic CFI_SRC_RET  = 1'b1;

  typedef struct packed {
    logic [63:0] tval;
    logic        src;
  } log_entry_t;

endpackage

// File: rtl/cfi_viol_fifo.sv
// Violation log FIFO. A pop frees the head slot in the same cycle, so a push
// and a pop on a full log are both accepted; clear wins over push and pop.
module cfi_viol_fifo
  import cfi_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = log_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clr_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t entry_i,
  output entry_t head_o,
  output logic   valid_o,
  output logic   drop_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]   count_r;
  entry_t           mem_r [DEPTH];
  logic             full_s, empty_s, do_push_s, do_pop_s;

  assign full_s    = (count_r == (PTR_W+1)'(DEPTH));
  assign empty_s   = (count_r == '0);
  assign do_pop_s  = pop_i & ~empty_s;
  assign do_push_s = push_i & (~full_s | pop_i);
  assign drop_o    = push_i & full_s & ~pop_i;
  assign valid_o   = ~empty_s;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; no reset needed since the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !clr_i && !rst_i) begin
      mem_r[wr_ptr_r] <= entry_i;
    end
  end

  // Present zeros rather than stale storage when the log is empty.
  always_comb begin
    if (empty_s) begin
      head_o = entry_t'(0);
    end else begin
      head_o = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/cfi_violation_handler.sv
// Turns call/ret CFI checker violations into a one-cycle exception plus a
// fixed-length redirect pulse, while counting and logging every violation.
module cfi_violation_handler
  import ariane_pkg::*;
  import cfi_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 11,
  parameter int unsigned LOG_DEPTH   = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             csr_en_i,
  input  exception_t       call_ex_i,
  input  exception_t       ret_ex_i,
  input  logic             log_rd_i,
  input  logic             log_clr_i,
  output exception_t       ex_o,
  output logic             cfi_signal_o,
  output logic             log_valid_o,
  output logic [63:0]      log_tval_o,
  output logic             log_src_o,
  output logic [CNT_W-1:0] viol_cnt_o,
  output logic             overflow_o,
  output logic [3:0]       leds_o
);

  localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);

  cfi_state_e       state_r, next_state_s;
  logic [HC_W-1:0]  hold_cnt_r, hold_cnt_nxt_s;
  exception_t       ex_r, ex_nxt_s;
  logic             cfi_r, toggle_r, overflow_r;
  logic [CNT_W-1:0] viol_cnt_r;
  logic [CNT_W:0]   cnt_sum_s;
  logic [1:0]       cnt_inc_s;
  logic             event_s, both_s, log_push_s, fifo_drop_s;
  log_entry_t       entry_s, head_s;

  assign event_s    = csr_en_i & (call_ex_i.valid | ret_ex_i.valid);
  assign both_s     = csr_en_i & call_ex_i.valid & ret_ex_i.valid;
  assign log_push_s = event_s & ~log_clr_i;
  assign entry_s    = call_ex_i.valid ? '{tval: call_ex_i.tval, src: CFI_SRC_CALL}
                                      : '{tval: ret_ex_i.tval,  src: CFI_SRC_RET};
  assign cnt_inc_s  = both_s ? 2'd2 : 2'd1;
  assign cnt_sum_s  = {1'b0, viol_cnt_r} + (CNT_W+1)'(cnt_inc_s);

  // Next-state logic; the hold counter holds the HOLD cycles still to go.
  always_comb begin
    next_state_s   = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    ex_nxt_s       = '0;
    case (state_r)
      IDLE: begin
        if (event_s) begin
          next_state_s   = REPORT;
          hold_cnt_nxt_s = '0;
          ex_nxt_s       = call_ex_i.valid ? call_ex_i : ret_ex_i;
          ex_nxt_s.valid = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      REPORT: begin
        if (HOLD_CYCLES > 32'd1) begin
          next_state_s   = HOLD;
          hold_cnt_nxt_s = HC_W'(HOLD_CYCLES - 32'd1);
        end else begin
          next_state_s   = IDLE;
          hold_cnt_nxt_s = '0;
        end
      end
      HOLD: begin
        if (hold_cnt_r <= HC_W'(1)) begin
          next_state_s   = IDLE;
          hold_cnt_nxt_s = '0;
        end else begin
          next_state_s   = HOLD;
          hold_cnt_nxt_s = hold_cnt_r - HC_W'(1);
        end
      end
      default: begin
        next_state_s   = IDLE;
        hold_cnt_nxt_s = '0;
      end
    endcase
  end

  // FSM and registered report outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      hold_cnt_r <= '0;
      ex_r       <= '0;
      cfi_r      <= 1'b0;
      toggle_r   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      ex_r       <= ex_nxt_s;
      cfi_r      <= (next_state_s != IDLE);
      if (state_r == IDLE && event_s) toggle_r <= ~toggle_r;
    end
  end

  // Saturating violation counter and sticky overflow; clear beats any event.
  always_ff @(posedge clk_i) begin
    if (rst_i || log_clr_i) begin
      viol_cnt_r <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (event_s) viol_cnt_r <= cnt_sum_s[CNT_W] ? '1 : cnt_sum_s[CNT_W-1:0];
      if (both_s || fifo_drop_s) overflow_r <= 1'b1;
    end
  end

  cfi_viol_fifo #(
    .DEPTH   (LOG_DEPTH),
    .entry_t (log_entry_t)
  ) u_log (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (log_clr_i),
    .push_i  (log_push_s),
    .pop_i   (log_rd_i),
    .entry_i (entry_s),
    .head_o  (head_s),
    .valid_o (log_valid_o),
    .drop_o  (fifo_drop_s)
  );

  assign ex_o         = ex_r;
  assign cfi_signal_o = cfi_r;
  assign log_tval_o   = head_s.tval;
  assign log_src_o    = head_s.src;
  assign viol_cnt_o   = viol_cnt_r;
  assign overflow_o   = overflow_r;
  assign leds_o       = {toggle_r, log_valid_o, overflow_r, (state_r != IDLE)};

endmodule

// File: tb/tb_cfi_violation_handler.sv
// Directed bench: table of single-event scenarios plus hand-written sequences
// for hold timing, log fill/overflow, clear, reset mid-hold and saturation.
module tb_cfi_violation_handler;
  import ariane_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, rd, clr;
  exception_t  call_ex, ret_ex;

  exception_t  ex1, ex2;
  logic        cfi1, lv1, src1, ovf1, cfi2, lv2, src2, ovf2;
  logic [63:0] tval1, tval2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;
  logic [3:0]  leds1, leds2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cfi_violation_handler dut (
    .clk_i(clk), .rst_i(rst), .csr_en_i(en), .call_ex_i(call_ex), .ret_ex_i(ret_ex),
    .log_rd_i(rd), .log_clr_i(clr), .ex_o(ex1), .cfi_signal_o(cfi1),
    .log_valid_o(lv1), .log_tval_o(tval1), .log_src_o(src1), .viol_cnt_o(cnt1),
    .overflow_o(ovf1), .leds_o(leds1)
  );

  cfi_violation_handler #(.HOLD_CYCLES(1), .LOG_DEPTH(2), .CNT_W(2)) dut_small (
    .clk_i(clk), .rst_i(rst), .csr_en_i(en), .call_ex_i(call_ex), .ret_ex_i(ret_ex),
    .log_rd_i(rd), .log_clr_i(clr), .ex_o(ex2), .cfi_signal_o(cfi2),
    .log_valid_o(lv2), .log_tval_o(tval2), .log_src_o(src2), .viol_cnt_o(cnt2),
    .overflow_o(ovf2), .leds_o(leds2)
  );

  typedef struct {
    logic        en;
    logic        cv;
    logic [63:0] ctv;
    logic        rv;
    logic [63:0] rtv;
    logic        exp_v;
    logic [63:0] exp_tval;
    logic [63:0] exp_cause;
    logic [15:0] exp_cnt;
    logic        exp_lv;
    logic        exp_src;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_in();
    call_ex = '0;
    ret_ex  = '0;
    rd      = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic set_ev(input logic cv, input logic [63:0] ctv, input logic rv, input logic [63:0] rtv);
    call_ex = '{cause: 64'd18, tval: ctv, valid: cv};
    ret_ex  = '{cause: 64'd19, tval: rtv, valid: rv};
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_list [4];
    logic        exp_ex, exp_cfi;
    logic [63:0] exp_tv;

    vecs[0] = '{1'b1, 1'b1, 64'h8000_0100, 1'b0, 64'h0,    1'b1, 64'h8000_0100, 64'd18, 16'd1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 64'h0,         1'b1, 64'h1234, 1'b1, 64'h1234,      64'd19, 16'd1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 64'hAAAA,      1'b1, 64'hBBBB, 1'b1, 64'hAAAA,      64'd18, 16'd2, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 64'h4444,      1'b0, 64'h0,    1'b0, 64'h0,         64'd0,  16'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 64'h5555,      1'b1, 64'h6666, 1'b0, 64'h0,         64'd0,  16'd0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 64'h7777,      1'b0, 64'h8888, 1'b0, 64'h0,         64'd0,  16'd0, 1'b0, 1'b0, 1'b0};

    en = 1'b1;
    clear_in();
    rst = 1'b1;
    cyc();
    chk("rst_ex",   ex1,   '0);
    chk("rst_cfi",  cfi1,  1'b0);
    chk("rst_lv",   lv1,   1'b0);
    chk("rst_tval", tval1, 64'h0);
    chk("rst_src",  src1,  1'b0);
    chk("rst_cnt",  cnt1,  16'd0);
    chk("rst_ovf",  ovf1,  1'b0);
    chk("rst_leds", leds1, 4'h0);
    rst = 1'b0;

    // Table: one event from reset, then outputs one cycle later and after the hold.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      en = vecs[i].en;
      set_ev(vecs[i].cv, vecs[i].ctv, vecs[i].rv, vecs[i].rtv);
      cyc();
      clear_in();
      en = 1'b1;
      chk($sformatf("v%0d_exv", i),   ex1.valid, vecs[i].exp_v);
      chk($sformatf("v%0d_extv", i),  ex1.tval,  vecs[i].exp_tval);
      chk($sformatf("v%0d_excs", i),  ex1.cause, vecs[i].exp_cause);
      chk($sformatf("v%0d_cfi", i),   cfi1,      vecs[i].exp_v);
      chk($sformatf("v%0d_cnt", i),   cnt1,      vecs[i].exp_cnt);
      chk($sformatf("v%0d_lv", i),    lv1,       vecs[i].exp_lv);
      chk($sformatf("v%0d_ltv", i),   tval1,     vecs[i].exp_tval);
      chk($sformatf("v%0d_src", i),   src1,      vecs[i].exp_src);
      chk($sformatf("v%0d_ovf", i),   ovf1,      vecs[i].exp_ovf);
      chk($sformatf("v%0d_leds", i),  leds1,
          {vecs[i].exp_v, vecs[i].exp_lv, vecs[i].exp_ovf, vecs[i].exp_v});
      repeat (11) cyc();
      chk($sformatf("v%0d_cfi_end", i), cfi1, 1'b0);
    end

    // Hold timing, an in-hold event, and a new report on the first idle cycle.
    do_reset();
    set_ev(1'b1, 64'h8000_0100, 1'b0, 64'h0);
    for (int k = 1; k <= 14; k++) begin
      cyc();
      clear_in();
      exp_ex  = (k == 1) || (k == 13);
      exp_cfi = (k <= 11) || (k >= 13);
      exp_tv  = (k == 1) ? 64'h8000_0100 : ((k == 13) ? 64'h3000 : 64'h0);
      chk($sformatf("seq_exv_k%0d", k),  ex1.valid, exp_ex);
      chk($sformatf("seq_extv_k%0d", k), ex1.tval,  exp_tv);
      chk($sformatf("seq_cfi_k%0d", k),  cfi1,      exp_cfi);
      if (k == 3)  set_ev(1'b0, 64'h0, 1'b1, 64'h2000);
      if (k == 12) set_ev(1'b1, 64'h3000, 1'b0, 64'h0);
    end
    chk("seq_cnt", cnt1, 16'd3);
    chk("seq_ovf", ovf1, 1'b0);
    exp_list[0] = 64'h8000_0100;
    exp_list[1] = 64'h2000;
    exp_list[2] = 64'h3000;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("seq_lv%0d", j),   lv1,   1'b1);
      chk($sformatf("seq_ltv%0d", j),  tval1, exp_list[j]);
      chk($sformatf("seq_src%0d", j),  src1,  (j == 1) ? 1'b1 : 1'b0);
      rd = 1'b1;
      cyc();
      rd = 1'b0;
    end
    chk("seq_empty", lv1, 1'b0);
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    chk("rd_empty_lv",  lv1,   1'b0);
    chk("rd_empty_tv",  tval1, 64'h0);
    chk("rd_empty_cnt", cnt1,  16'd3);
    repeat (12) cyc();

    // Fill past depth, push+pop on full, then clear.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_ev(1'b1, 64'h100 + 64'(i), 1'b0, 64'h0);
      cyc();
      chk($sformatf("fill_ovf%0d", i), ovf1, (i == 4) ? 1'b1 : 1'b0);
    end
    clear_in();
    chk("fill_cnt",  cnt1,  16'd5);
    chk("fill_head", tval1, 64'h100);
    set_ev(1'b1, 64'h105, 1'b0, 64'h0);
    rd = 1'b1;
    cyc();
    clear_in();
    chk("pp_cnt",  cnt1,  16'd6);
    chk("pp_ovf",  ovf1,  1'b1);
    exp_list[0] = 64'h101;
    exp_list[1] = 64'h102;
    exp_list[2] = 64'h103;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("fill_ltv%0d", j), tval1, exp_list[j]);
      rd = 1'b1;
      cyc();
      rd = 1'b0;
    end
    chk("fill_last", tval1, 64'h105);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_lv",  lv1,  1'b0);
    chk("clr_ovf", ovf1, 1'b0);
    chk("clr_cnt", cnt1, 16'd0);
    repeat (12) cyc();
    set_ev(1'b1, 64'h777, 1'b1, 64'h888);
    clr = 1'b1;
    cyc();
    clear_in();
    chk("clrev_exv",  ex1.valid, 1'b1);
    chk("clrev_extv", ex1.tval,  64'h777);
    chk("clrev_cnt",  cnt1,      16'd0);
    chk("clrev_lv",   lv1,       1'b0);
    chk("clrev_ovf",  ovf1,      1'b0);
    repeat (12) cyc();

    // Reset asserted in the third cycle of the redirect.
    do_reset();
    set_ev(1'b1, 64'h55, 1'b0, 64'h0);
    cyc();
    clear_in();
    cyc();
    cyc();
    chk("rsth_cfi_pre", cfi1, 1'b1);
    rst = 1'b1;
    cyc();
    chk("rsth_cfi", cfi1, 1'b0);
    chk("rsth_ex",  ex1,  '0);
    chk("rsth_cnt", cnt1, 16'd0);
    rst = 1'b0;
    cyc();
    chk("rsth_cfi2", cfi1, 1'b0);

    // Single-cycle hold and counter saturation on the small instance.
    do_reset();
    set_ev(1'b1, 64'h9, 1'b0, 64'h0);
    cyc();
    clear_in();
    chk("sm_exv",  ex2.valid, 1'b1);
    chk("sm_cfi",  cfi2,      1'b1);
    cyc();
    chk("sm_cfi_off", cfi2,      1'b0);
    chk("sm_exv_off", ex2.valid, 1'b0);
    chk("sm_cnt1",    cnt2,      2'd1);
    set_ev(1'b1, 64'hA, 1'b1, 64'hB);
    cyc();
    chk("sm_cnt3", cnt2, 2'd3);
    cyc();
    chk("sm_sat", cnt2, 2'd3);
    clear_in();
    chk("sm_ovf", ovf2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfi_violation_handler.md
CFI_VIOLATION_HANDLER -- requirements
Module: cfi_violation_handler

Interface
REQ-001 Parameter HOLD_CYCLES, default 11, number of cycles cfi_signal_o stays high per reported violation (minimum 1).
REQ-002 Parameter LOG_DEPTH, default 4, violation log FIFO entries (power of two, minimum 2).
REQ-003 Parameter CNT_W, default 16, violation counter width.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 csr_en_i  in  1  CFI enforcement enable.
REQ-007 call_ex_i  in  exception_t  violation from the call/nop checker; .valid qualifies it.
REQ-008 ret_ex_i  in  exception_t  violation from the ret/nop checker; .valid qualifies it.
REQ-009 log_rd_i  in  1  pop the log head.
REQ-010 log_clr_i  in  1  empty the log, clear overflow_o, zero the counter.
REQ-011 ex_o  out  exception_t  one-cycle exception to the commit/CSR path.
REQ-012 cfi_signal_o  out  1  core redirect/kill request.
REQ-013 log_valid_o  out  1  log not empty.
REQ-014 log_tval_o  out  64  tval of the log head.
REQ-015 log_src_o  out  1  source of the log head: 0 = call, 1 = ret.
REQ-016 viol_cnt_o  out  CNT_W  count of accepted violations.
REQ-017 overflow_o  out  1  sticky flag: at least one violation was not logged.
REQ-018 leds_o  out  4  debug: [0] busy, [1] overflow, [2] log_valid, [3] toggles on each report.

Function
REQ-019 An event is a cycle where call_ex_i.valid or ret_ex_i.valid is high while csr_en_i is high; inputs seen while csr_en_i is low are ignored entirely.
REQ-020 FSM states: IDLE, REPORT, HOLD.
REQ-021 IDLE to REPORT on an event; the reported exception is latched as call_ex_i when it is valid, otherwise ret_ex_i (call has priority).
REQ-022 In REPORT, ex_o equals the latched exception with valid = 1 for exactly one cycle; the next state is HOLD when HOLD_CYCLES > 1, otherwise IDLE.
REQ-023 cfi_signal_o is high in REPORT and HOLD; a hold counter makes the total high time exactly HOLD_CYCLES cycles, after which the FSM returns to IDLE.
REQ-024 Latency: an event in cycle N gives ex_o.valid and cfi_signal_o high in cycle N+1, and cfi_signal_o low from cycle N+HOLD_CYCLES+1.
REQ-025 Events in REPORT or HOLD are counted and logged but not re-reported and do not extend the hold.
REQ-026 An event arriving in the cycle the FSM returns to IDLE is treated as a new report.
REQ-027 ex_o is all zeros whenever the FSM is not in REPORT.
REQ-028 Every event increments viol_cnt_o by 1, or by 2 when both inputs are valid; the counter saturates at all ones.
REQ-029 Each event pushes one log entry {tval, src}, call first; when both inputs are valid, ret is not logged and overflow_o is set.
REQ-030 When the log is full and no pop happens in the same cycle, the push is dropped and overflow_o is set; a push and a pop in the same cycle on a full log are both accepted.
REQ-031 log_rd_i on an empty log has no effect; pointers wrap modulo LOG_DEPTH.
REQ-032 log_clr_i takes priority over a push or pop in the same cycle; an event in that cycle is still reported but is neither counted nor logged.

Reset
REQ-033 While rst_i is high: FSM in IDLE, hold counter 0, ex_o all zeros, cfi_signal_o 0, log empty, log_tval_o 0, log_src_o 0, viol_cnt_o 0, overflow_o 0, leds_o 0.
REQ-034 Reset asserted during REPORT or HOLD ends the redirect at the next clock edge, with no further ex_o output.

Structure
REQ-035 The FSM state enum, the log entry struct and the CFI_SRC_CALL/CFI_SRC_RET constants belong in a shared cfi_pkg; exception_t comes from ariane_pkg.
REQ-036 The log is a single sub-module, cfi_viol_fifo, with parameters DEPTH and entry type.

Verification
REQ-037 Single call violation, tval 0x8000_0100, in cycle 5 -> ex_o.valid only in cycle 6 with tval 0x8000_0100; cfi_signal_o high in cycles 6-16; viol_cnt_o = 1; log head {0x8000_0100, 0}.
REQ-038 Call and ret valid in the same cycle -> reported tval is the call's; viol_cnt_o = 2; one log entry; overflow_o = 1.
REQ-039 Second event 3 cycles after the first -> no second ex_o; cfi_signal_o low exactly HOLD_CYCLES cycles after the first report; viol_cnt_o = 2; 2 log entries.
REQ-040 Five events with LOG_DEPTH = 4 and no reads -> 4 entries held in order; overflow_o = 1; log_clr_i then gives log_valid_o = 0, overflow_o = 0, viol_cnt_o = 0.
REQ-041 Event with csr_en_i = 0 -> no ex_o, no cfi_signal_o, count unchanged; rst_i in cycle 3 of a hold -> cfi_signal_o = 0 the next cycle.
